// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt pending controller.
package irq_pkg;

  localparam int unsigned N_IRQ = 16;
  localparam int unsigned ID_W  = 4;

  typedef enum logic {
    IDLE,
    PRESENT
  } irq_state_t;

  // One-hot vector selecting a single request id.
  function automatic logic [N_IRQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    return {{(N_IRQ-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage

// File: rtl/irq_req_sync.sv
// Single-bit multi-flop synchroniser for one asynchronous request line.
module irq_req_sync
  import irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending controller: synchronises requests, latches pending bits,
// feeds an external priority encoder and presents the winner via valid/ack.
// Optional macro IRQ_MASK_EN adds the irq_mask input gating enc_w.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LEVEL_MODE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] req,
`ifdef IRQ_MASK_EN
  input  logic [N_IRQ-1:0] irq_mask,
`endif
  output logic [N_IRQ-1:0] enc_w,
  input  logic [ID_W-1:0]  enc_y,
  input  logic             enc_z,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack,
  output logic [N_IRQ-1:0] pending,
  output logic             irq_lost
);

  irq_state_t       state;
  logic [N_IRQ-1:0] s;
  logic [N_IRQ-1:0] prev;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] clr_vec;
  logic             ack_clr;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
    irq_req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (req[i]),
      .q     (s[i])
    );
  end

  // Delay the synchronised lines by one cycle for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= '0;
    else        prev <= s;
  end

  assign rise    = s & ~prev;
  assign ack_clr = (state == PRESENT) && irq_ack;
  assign clr_vec = ack_clr ? id_onehot(irq_id) : '0;

  // Pending register: sticky edge capture (set beats clear) or plain level copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               pending <= '0;
    else if (LEVEL_MODE != 0) pending <= s;
    else                      pending <= (pending & ~clr_vec) | rise;
  end

  // Sticky overflow flag: an edge arrived on a bit that stays pending anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        irq_lost <= 1'b0;
    else if (LEVEL_MODE == 0 && |(rise & pending & ~clr_vec)) irq_lost <= 1'b1;
  end

`ifdef IRQ_MASK_EN
  assign enc_w = pending & irq_mask;
`else
  assign enc_w = pending;
`endif

  // Handshake FSM: latch the encoder winner and hold it until acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enc_z) begin
            irq_id    <= enc_y;
            irq_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (irq_ack) begin
            irq_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          irq_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
